// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file write port.
// Op encodings are reused by the control unit decoder.
package reg_file_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } wr_op_e;

endpackage

// File: rtl/reg_file_mp_reg_op_alu.sv
// Write-port arithmetic: result plus zero/carry status.
// Purely combinational.
module reg_op_alu
  import reg_file_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  wr_op_e            op,
  input  logic [DATA_W-1:0] old_val,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (op)
      OP_LOAD: result = data_in;
      OP_INC: begin
        result = old_val + 1'b1;
        carry  = (old_val == '1);
      end
      OP_DEC: begin
        result = old_val - 1'b1;
        carry  = (old_val == '0);
      end
      OP_CLR: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: one arithmetic write port,
// two registered read ports with write-to-read bypass.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic              reg_clk,
  input  logic              reg_rst_n,
  input  logic              wr,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [1:0]        wr_op,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_a,
  input  logic              rd_b,
  input  logic [SEL_W-1:0]  sel_a,
  input  logic [SEL_W-1:0]  sel_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  output logic              valid_a,
  output logic              valid_b,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              sel_err
);

  localparam logic [SEL_W:0] NREGS = (SEL_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              wr_ok;
  logic              ok_a;
  logic              ok_b;
  logic              commit;
  logic [DATA_W-1:0] old_val;
  logic [DATA_W-1:0] result;
  logic              res_zero;
  logic              res_carry;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;

  assign wr_ok  = ({1'b0, wr_sel} < NREGS);
  assign ok_a   = ({1'b0, sel_a} < NREGS);
  assign ok_b   = ({1'b0, sel_b} < NREGS);
  assign commit = wr && wr_ok;

  assign old_val = wr_ok ? regs[wr_sel] : '0;

  reg_op_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op      (wr_op_e'(wr_op)),
    .old_val (old_val),
    .data_in (data_in),
    .result  (result),
    .zero    (res_zero),
    .carry   (res_carry)
  );

  // Same-cycle write to the read register forwards the new value.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (ok_a) begin
      rdata_a = (commit && sel_a == wr_sel) ? result : regs[sel_a];
    end
    if (ok_b) begin
      rdata_b = (commit && sel_b == wr_sel) ? result : regs[sel_b];
    end
  end

  always_ff @(posedge reg_clk) begin
    if (!reg_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      data_out_a <= '0;
      data_out_b <= '0;
      valid_a    <= 1'b0;
      valid_b    <= 1'b0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      if (commit) begin
        regs[wr_sel] <= result;
        zero_flag    <= res_zero;
        carry_flag   <= res_carry;
      end
      valid_a <= rd_a;
      valid_b <= rd_b;
      if (rd_a) data_out_a <= rdata_a;
      if (rd_b) data_out_b <= rdata_b;
      sel_err <= (wr && !wr_ok) ||
                 (rd_a && !ok_a) ||
                 (rd_b && !ok_b);
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a 4-entry and a
// 5-entry (non power-of-two) instance.
module tb_reg_file_mp;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  logic       rst_n, wr, rd_a, rd_b;
  logic [1:0] wr_sel, sel_a, sel_b, wr_op;
  logic [7:0] data_in;
  logic [7:0] dout_a, dout_b;
  logic       v_a, v_b, zf, cf, serr;

  reg_file_mp u4 (
    .reg_clk    (clk),
    .reg_rst_n  (rst_n),
    .wr         (wr),
    .wr_sel     (wr_sel),
    .wr_op      (wr_op),
    .data_in    (data_in),
    .rd_a       (rd_a),
    .rd_b       (rd_b),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .data_out_a (dout_a),
    .data_out_b (dout_b),
    .valid_a    (v_a),
    .valid_b    (v_b),
    .zero_flag  (zf),
    .carry_flag (cf),
    .sel_err    (serr)
  );

  logic       rst5_n, wr5, rd5_a, rd5_b;
  logic [2:0] wr5_sel, sel5_a, sel5_b;
  logic [1:0] wr5_op;
  logic [7:0] data5_in;
  logic [7:0] dout5_a, dout5_b;
  logic       v5_a, v5_b, zf5, cf5, serr5;

  reg_file_mp #(
    .DATA_W   (8),
    .NUM_REGS (5)
  ) u5 (
    .reg_clk    (clk),
    .reg_rst_n  (rst5_n),
    .wr         (wr5),
    .wr_sel     (wr5_sel),
    .wr_op      (wr5_op),
    .data_in    (data5_in),
    .rd_a       (rd5_a),
    .rd_b       (rd5_b),
    .sel_a      (sel5_a),
    .sel_b      (sel5_b),
    .data_out_a (dout5_a),
    .data_out_b (dout5_b),
    .valid_a    (v5_a),
    .valid_b    (v5_b),
    .zero_flag  (zf5),
    .carry_flag (cf5),
    .sel_err    (serr5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    wr = 0; rd_a = 0; rd_b = 0;
    wr5 = 0; rd5_a = 0; rd5_b = 0;
  endtask

  initial begin
    idle();
    wr_sel = 0; sel_a = 0; sel_b = 0; wr_op = 0;
    data_in = 0;
    wr5_sel = 0; sel5_a = 0; sel5_b = 0; wr5_op = 0;
    data5_in = 0;
    rst_n = 0; rst5_n = 0;
    tick(); tick();
    check("rst_dout_a", dout_a, 0);
    check("rst_dout_b", dout_b, 0);
    check("rst_valid",  {v_a, v_b}, 0);
    check("rst_flags",  {zf, cf, serr}, 0);
    rst_n = 1; rst5_n = 1;

    for (int i = 0; i < 4; i++) begin
      rd_a = 1; sel_a = 2'(i);
      tick();
      check("rst_read_a", dout_a, 0);
      check("rst_read_va", v_a, 1);
    end
    idle();
    tick();
    check("va_drops", v_a, 0);
    check("flags_idle", {zf, cf}, 0);

    wr = 1; wr_op = 2'b00; wr_sel = 2; data_in = 8'hA5;
    tick();
    idle(); rd_b = 1; sel_b = 2;
    tick();
    check("load_rd_b", dout_b, 8'hA5);
    check("load_vb", v_b, 1);
    check("load_zf", zf, 0);
    idle();
    tick();
    check("hold_b", dout_b, 8'hA5);
    check("hold_vb", v_b, 0);

    wr = 1; wr_op = 2'b00; wr_sel = 1; data_in = 8'hFF;
    tick();
    wr_op = 2'b01;
    tick();
    check("inc_cf", cf, 1);
    check("inc_zf", zf, 1);
    idle(); rd_a = 1; sel_a = 1;
    tick();
    check("inc_val", dout_a, 8'h00);
    idle(); wr = 1; wr_op = 2'b10; wr_sel = 1;
    tick();
    check("dec_cf", cf, 1);
    check("dec_zf", zf, 0);
    idle(); rd_a = 1; sel_a = 1;
    tick();
    check("dec_val", dout_a, 8'hFF);
    idle(); wr = 1; wr_op = 2'b10; wr_sel = 1;
    tick();
    check("dec_nowrap_cf", cf, 0);
    idle(); rd_a = 1; sel_a = 1;
    tick();
    check("dec_nowrap", dout_a, 8'hFE);

    idle();
    wr = 1; wr_op = 2'b00; wr_sel = 3; data_in = 8'h3C;
    rd_a = 1; sel_a = 3; rd_b = 1; sel_b = 3;
    tick();
    check("byp_a", dout_a, 8'h3C);
    check("byp_b", dout_b, 8'h3C);

    idle();
    wr = 1; wr_op = 2'b01; wr_sel = 2;
    rd_b = 1; sel_b = 2; rd_a = 1; sel_a = 1;
    tick();
    check("byp_inc_b", dout_b, 8'hA6);
    check("nobyp_a", dout_a, 8'hFE);

    idle(); wr = 1; wr_op = 2'b11; wr_sel = 2;
    tick();
    check("clr_flags", {zf, cf}, 2'b10);
    idle(); rd_b = 1; sel_b = 2;
    tick();
    check("clr_val", dout_b, 0);

    idle();
    wr5 = 1; wr5_op = 2'b00; wr5_sel = 4; data5_in = 8'h22;
    tick();
    wr5_op = 2'b11; wr5_sel = 0;
    tick();
    check("u5_clr_zf", zf5, 1);
    wr5 = 1; wr5_op = 2'b00; wr5_sel = 6; data5_in = 8'h11;
    rd5_a = 1; sel5_a = 7;
    tick();
    check("oor_dout", dout5_a, 0);
    check("oor_valid", v5_a, 1);
    check("oor_err", serr5, 1);
    check("oor_flags", {zf5, cf5}, 2'b10);
    idle(); rd5_a = 1; sel5_a = 4;
    tick();
    check("oor_err_drop", serr5, 0);
    check("u5_top_reg", dout5_a, 8'h22);
    idle(); rd5_b = 1; sel5_b = 5;
    tick();
    check("oor_err_b", serr5, 1);
    check("oor_dout_b", dout5_b, 0);

    idle();
    wr = 1; wr_op = 2'b00; wr_sel = 0; data_in = 8'h55;
    rd_a = 1; sel_a = 3;
    rst_n = 0;
    tick();
    check("mrst_douts", {dout_a, dout_b}, 0);
    check("mrst_misc", {v_a, v_b, zf, cf, serr}, 0);
    rst_n = 1;
    idle(); rd_a = 1; sel_a = 0; rd_b = 1; sel_b = 3;
    tick();
    check("mrst_reg0", dout_a, 0);
    check("mrst_reg3", dout_b, 0);

    idle();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised general-purpose register file for the microprocessor datapath; it is the successor to the fixed 4x8 single-port register block.
- Provides one write port with in-place arithmetic ops (load/inc/dec/clear) and two independent registered read ports for ALU operand fetch.
- Includes write-to-read bypass, per-port read-valid strobes, zero/carry status on writes and out-of-range select detection.

Parameters:
- DATA_W, 8, register width in bits (>=2)
- NUM_REGS, 4, number of registers (2..256, need not be a power of two)
- SEL_W, $clog2(NUM_REGS), select width (derived; do not override)

Ports:
- reg_clk  in  1  single clock, all state on rising edge
- reg_rst_n  in  1  synchronous, active-low reset
- wr  in  1  write-port enable
- wr_sel  in  SEL_W  destination register
- wr_op  in  2  00 load data_in, 01 increment, 10 decrement, 11 clear
- data_in  in  DATA_W  load data
- rd_a, rd_b  in  1  read enables, ports A/B
- sel_a, sel_b  in  SEL_W  read selects
- data_out_a, data_out_b  out  DATA_W  registered read data
- valid_a, valid_b  out  1  one-cycle strobe: data_out_x updated this cycle
- zero_flag  out  1  last committed write result == 0
- carry_flag  out  1  last inc wrapped max->0 or dec wrapped 0->max; 0 for load/clear
- sel_err  out  1  one-cycle pulse: any enabled port used select >= NUM_REGS

Behaviour:
- Reset (reg_rst_n=0 at posedge): all registers, data_out_a/b, valid_a/b, zero_flag, carry_flag, sel_err <= 0. Reset has priority over wr/rd in the same cycle; an operation in flight is discarded.
- Write: when wr=1 at posedge, regs[wr_sel] <= result. Result: load=data_in; inc=regs+1 mod 2^DATA_W; dec=regs-1 mod 2^DATA_W; clear=0.
- Flags update only on a committed write; otherwise they hold. zero_flag=(result==0). carry_flag per op as above.
- Read: when rd_x=1 at posedge, data_out_x <= regs[sel_x] and valid_x <= 1. Latency is 1 cycle.
- When rd_x=0, valid_x <= 0 and data_out_x holds its previous value.
- Bypass: if rd_x and wr hit the same valid register in the same cycle, data_out_x gets the new result, not the old value. Both ports bypass independently; A and B may select the same register.
- Out-of-range select (only possible when NUM_REGS is not 2^SEL_W): a write is suppressed and flags hold; a read returns 0 with valid_x=1. sel_err=1 for that one cycle (OR over all enabled ports), else 0.
- Inputs are ignored when the corresponding enable is low; there is no backpressure.

Decomposition:
- Shared package reg_file_pkg holds the wr_op encodings (OP_LOAD, OP_INC, OP_DEC, OP_CLR) as a 2-bit enum typedef, for reuse by the control unit decoder.
- One sub-module, reg_op_alu: combinational result, zero and carry from (op, old value, data_in). The main module holds the storage, read ports, bypass and flags.

Test Plan:
- Reset then rd_a sel_a=0..3 -> data_out_a=8'h00 each, valid_a=1 one cycle after each read; flags=0.
- wr op=load sel=2 data_in=8'hA5; next cycle rd_b sel_b=2 -> data_out_b=8'hA5, zero_flag=0.
- Load reg1=8'hFF, then op=inc sel=1 -> reg1=8'h00, carry_flag=1, zero_flag=1. Then op=dec sel=1 -> 8'hFF, carry_flag=1, zero_flag=0.
- Same cycle: wr load sel=3 data_in=8'h3C, rd_a sel_a=3, rd_b sel_b=3 -> both outputs 8'h3C next cycle (bypass).
- NUM_REGS=5, SEL_W=3: wr sel=6 data_in=8'h11 and rd_a sel_a=7 -> no register changes, data_out_a=0, valid_a=1, sel_err=1 for one cycle.
- Mid-stream reset: wr load sel=0 8'h55 with reg_rst_n=0 the same cycle -> reg0=0 and all outputs 0 after that edge.
